// File: rtl/pal_mode_sequencer.sv
// rtl/pal_mode_sequencer.sv - interlaced/progressive mode switch sequencer for the PAL test frame generator
// Debounced button and auto-cycle timer requests, applied at frame boundaries with a post-switch video mute.
module pal_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned MUTE_FRAMES     = 4,
  parameter int unsigned AUTO_FRAMES     = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic auto_en_i,
  input  logic frame_start_i,
  output logic mode_o,
  output logic video_mute_o,
  output logic mode_changed_o,
  output logic busy_o
);

  localparam int DBW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int MW  = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
  localparam int FW  = (AUTO_FRAMES > 0) ? $clog2(AUTO_FRAMES + 1) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0]  FRM_LAST  = FW'(AUTO_FRAMES - 1);
  localparam logic [MW-1:0]  MUTE_INIT = MW'(MUTE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_MUTE    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic           db_q, db_d, btn_req_q, btn_req_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [FW-1:0]  frm_cnt_q, frm_cnt_d;
  logic [MW-1:0]  mute_cnt_q, mute_cnt_d;
  logic           mode_q, mode_d, video_mute_q, video_mute_d;
  logic           mode_changed_q, mode_changed_d, busy_q, busy_d;
  logic           idle, auto_req, req;

  always_comb begin
    sync1_d   = btn_i;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    btn_req_d = 1'b0;
    // Count consecutive cycles the synced level disagrees with the debounced one.
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d      = sync2_q;
        btn_req_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    idle     = (state_q == S_IDLE);
    auto_req = auto_en_i && idle && frame_start_i && (frm_cnt_q == FRM_LAST);
    req      = btn_req_q || auto_req;

    frm_cnt_d = frm_cnt_q;
    if (!auto_en_i || (idle && req)) begin
      frm_cnt_d = '0;
    end else if (idle && frame_start_i) begin
      frm_cnt_d = frm_cnt_q + 1'b1;
    end

    state_d        = state_q;
    mode_d         = mode_q;
    mute_cnt_d     = mute_cnt_q;
    video_mute_d   = video_mute_q;
    mode_changed_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (frame_start_i) begin
          mode_d         = ~mode_q;
          mode_changed_d = 1'b1;
          mute_cnt_d     = MUTE_INIT;
          if (MUTE_FRAMES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_MUTE;
            video_mute_d = 1'b1;
          end
        end
      end
      S_MUTE: begin
        if (frame_start_i) begin
          mute_cnt_d = mute_cnt_q - 1'b1;
          if (mute_cnt_q <= MW'(1)) begin
            state_d      = S_IDLE;
            video_mute_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      db_q           <= 1'b0;
      db_cnt_q       <= '0;
      btn_req_q      <= 1'b0;
      frm_cnt_q      <= '0;
      mute_cnt_q     <= '0;
      mode_q         <= 1'b0;
      video_mute_q   <= 1'b0;
      mode_changed_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      db_q           <= db_d;
      db_cnt_q       <= db_cnt_d;
      btn_req_q      <= btn_req_d;
      frm_cnt_q      <= frm_cnt_d;
      mute_cnt_q     <= mute_cnt_d;
      mode_q         <= mode_d;
      video_mute_q   <= video_mute_d;
      mode_changed_q <= mode_changed_d;
      busy_q         <= busy_d;
    end
  end

  assign mode_o         = mode_q;
  assign video_mute_o   = video_mute_q;
  assign mode_changed_o = mode_changed_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_pal_mode_sequencer.sv
// tb/tb_pal_mode_sequencer.sv - self-checking bench for pal_mode_sequencer
// Frame-level reference model, directed scenarios and randomized button/auto/reset traffic.
module tb_pal_mode_sequencer;
  localparam int D = 8;
  localparam int M = 2;
  localparam int A = 3;

  logic clk, rst, btn, auto_en, fs;
  logic mode_o, video_mute_o, mode_changed_o, busy_o;

  pal_mode_sequencer #(.DEBOUNCE_CYCLES(D), .MUTE_FRAMES(M), .AUTO_FRAMES(A)) dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .auto_en_i(auto_en), .frame_start_i(fs),
    .mode_o(mode_o), .video_mute_o(video_mute_o), .mode_changed_o(mode_changed_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: button history as a run length of the synced level, the
  // sequencer as "toggle pending" plus "mute frames left".
  int m_valid = 0;
  int sp0, sp1, last_s, run, db, breq, nbreq, frm, pend, mute_left, m_mode, m_chg, m_last_fs;
  int s, idle_m, auto_hit, req_m;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid = 1; sp0 = 0; sp1 = 0; last_s = 0; run = 0; db = 0; breq = 0;
      frm = 0; pend = 0; mute_left = 0; m_mode = 0; m_chg = 0;
    end else if (m_valid != 0) begin
      s = sp1;
      if (s == last_s) run++;
      else begin
        run = 1;
        last_s = s;
      end
      nbreq = 0;
      if (run >= D && s != db) begin
        db = s;
        nbreq = s;
      end
      idle_m   = (pend == 0 && mute_left == 0) ? 1 : 0;
      auto_hit = (auto_en && idle_m != 0 && fs && frm == A - 1) ? 1 : 0;
      req_m    = (breq != 0 || auto_hit != 0) ? 1 : 0;
      if (!auto_en || (idle_m != 0 && req_m != 0)) frm = 0;
      else if (idle_m != 0 && fs) frm++;
      m_chg = 0;
      if (idle_m != 0) begin
        if (req_m != 0) pend = 1;
      end else if (pend != 0) begin
        if (fs) begin
          m_mode = 1 - m_mode;
          m_chg = 1;
          pend = 0;
          mute_left = M;
        end
      end else if (fs) begin
        mute_left--;
      end
      breq = nbreq;
      sp1 = sp0;
      sp0 = int'(btn);
    end
    m_last_fs = int'(fs);
  end

  int n_chg = 0, n_mute = 0, n_busy = 0, last_chg_cyc = -1;

  always @(negedge clk) begin
    if (m_valid != 0) begin
      chk("mode", int'(mode_o), m_mode);
      chk("video_mute", int'(video_mute_o), (mute_left > 0) ? 1 : 0);
      chk("mode_changed", int'(mode_changed_o), m_chg);
      chk("busy", int'(busy_o), (pend != 0 || mute_left > 0) ? 1 : 0);
      if (mode_changed_o) begin
        n_chg++;
        last_chg_cyc = cyc;
        chk("chg_after_frame_start", m_last_fs, 1);
      end
      if (video_mute_o) n_mute++;
      if (busy_o) n_busy++;
    end
  end

  task automatic step();
    @(negedge clk);
    fcnt++;
    fs = (fcnt % 100 == 0);
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  task automatic align(input int r);
    for (int i = 0; i < 100; i++) begin
      step();
      if (fcnt % 100 == r) break;
    end
  endtask

  int b_chg, b_mute, b_busy, req_edge, done, prev_mode, hold;

  initial begin
    rst = 1'b1; btn = 1'b0; auto_en = 1'b0; fs = 1'b0;
    run_n(3);
    rst = 1'b0;
    chk("rst_mode", int'(mode_o), 0);
    chk("rst_mute", int'(video_mute_o), 0);
    chk("rst_chg", int'(mode_changed_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    run_n(20);

    // Bouncy press then held: one toggle, two muted frames.
    b_chg = n_chg; b_mute = n_mute;
    for (int i = 0; i < 3; i++) begin
      btn = 1'($urandom % 2);
      step();
    end
    btn = 1'b1;
    run_n(30);
    btn = 1'b0;
    run_n(400);
    chk("p1_toggles", n_chg - b_chg, 1);
    chk("p1_mute_cycles", n_mute - b_mute, 200);
    chk("p1_mode", int'(mode_o), 1);

    // Short pulses never reach the debounce threshold.
    b_busy = n_busy; b_chg = n_chg;
    for (int i = 0; i < 6; i++) begin
      btn = 1'b1;
      run_n($urandom_range(1, D - 3));
      btn = 1'b0;
      run_n($urandom_range(12, 30));
    end
    chk("p2_busy_cycles", n_busy - b_busy, 0);
    chk("p2_toggles", n_chg - b_chg, 0);
    chk("p2_mode", int'(mode_o), 1);

    // Auto cycle over 13 frames: toggles at frames 4 and 10.
    b_chg = n_chg; b_mute = n_mute;
    align(1);
    auto_en = 1'b1;
    run_n(1310);
    auto_en = 1'b0;
    run_n(5);
    chk("p3_toggles", n_chg - b_chg, 2);
    chk("p3_mute_cycles", n_mute - b_mute, 400);
    chk("p3_mode", int'(mode_o), 1);

    // Button and auto request in the same frame_start cycle, then a press during mute.
    b_chg = n_chg;
    align(1);
    auto_en = 1'b1;
    run_n(289);
    btn = 1'b1;
    run_n(10);
    req_edge = cyc + 1;
    run_n(20);
    btn = 1'b0;
    run_n(110);
    btn = 1'b1;
    run_n(20);
    btn = 1'b0;
    run_n(200);
    auto_en = 1'b0;
    run_n(50);
    chk("p4_toggles", n_chg - b_chg, 1);
    chk("p4_toggle_cycle", last_chg_cyc, req_edge + 100);
    chk("p4_mode", int'(mode_o), 0);

    // Button request landing on a frame_start waits for the following one.
    align(90);
    btn = 1'b1;
    run_n(10);
    req_edge = cyc + 1;
    run_n(20);
    btn = 1'b0;
    run_n(150);
    chk("p5_toggle_cycle", last_chg_cyc, req_edge + 100);
    chk("p5_mode", int'(mode_o), 1);
    run_n(300);

    // Reset while muted with mode=1.
    done = 0;
    for (int k = 0; k < 3 && done == 0; k++) begin
      prev_mode = m_mode;
      btn = 1'b1;
      run_n(20);
      btn = 1'b0;
      for (int i = 0; i < 300 && m_mode == prev_mode; i++) step();
      run_n(50);
      if (m_mode == 1) done = 1;
      else run_n(250);
    end
    chk("p6_setup", done, 1);
    chk("p6_mute_before", int'(video_mute_o), 1);
    chk("p6_mode_before", int'(mode_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("p6_mode", int'(mode_o), 0);
    chk("p6_mute", int'(video_mute_o), 0);
    chk("p6_busy", int'(busy_o), 0);
    b_chg = n_chg;
    run_n(150);
    chk("p6_no_toggle", n_chg - b_chg, 0);
    chk("p6_mode_after", int'(mode_o), 0);

    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = 1'b0;
      if (hold == 0) begin
        btn = 1'($urandom % 2);
        hold = $urandom_range(1, 20);
      end
      hold--;
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    run_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
